// File: rtl/usb2_ep_in_packer.sv
// usb2_ep_in_packer: IN-endpoint packetiser in the ext_clk domain.
// Packs a byte stream into endpoint buffer packets. A packet closes on MAX_PKT
// bytes, s_last, an idle timeout or enable falling, and each packet is handed
// over with a 4-phase commit/commit_ack handshake.
// Optional build macro: USB2_PACKER_TS_SYNC_EN (drop bytes until TS sync 0x47
// is seen at a 188-byte packet boundary).
//
// state       | meaning
// IDLE        | waiting for enable && buf_in_ready
// FILL        | accepting stream bytes into the buffer
// COMMIT      | commit raised, waiting for ack high
// WAIT_ACK_LO | commit dropped, waiting for ack low
module usb2_ep_in_packer #(
  parameter int ADDR_W       = 11,
  parameter int MAX_PKT      = 512,
  parameter int FLUSH_CYCLES = 4096
) (
  input  logic              ext_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] buf_in_addr,
  output logic [7:0]        buf_in_data,
  output logic              buf_in_wren,
  input  logic              buf_in_ready,
  output logic              buf_in_commit,
  output logic [10:0]       buf_in_commit_len,
  input  logic              buf_in_commit_ack,
  output logic [15:0]       stat_pkt_cnt,
  output logic [15:0]       stat_drop_cnt
);

  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(MAX_PKT - 1);
  localparam logic [TW-1:0] LP_TMR_LAST = TW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_FILL        = 2'd1,
    S_COMMIT      = 2'd2,
    S_WAIT_ACK_LO = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_timer;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_wren;
  logic              r_commit;
  logic [10:0]       r_commit_len;
  logic [15:0]       r_pkt_cnt;

  logic w_accept;
  logic w_write;
  logic w_drop;
  logic w_ack_hit;

`ifdef USB2_PACKER_TS_SYNC_EN
  logic [7:0]  r_pos;
  logic [15:0] r_drop_cnt;

  // A byte arriving at a TS boundary that is not a sync byte is swallowed.
  assign w_drop        = w_accept && (r_pos == 8'd0) && (s_data != 8'h47);
  assign stat_drop_cnt = r_drop_cnt;

  // TS position tracks 188-byte alignment across USB packets; enable low resyncs.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n)        r_pos <= 8'd0;
    else if (!enable)    r_pos <= 8'd0;
    else if (w_write)    r_pos <= (r_pos == 8'd187) ? 8'd0 : r_pos + 8'd1;
  end

  // Saturating count of swallowed bytes.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n)                              r_drop_cnt <= 16'd0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
`else
  assign w_drop        = 1'b0;
  assign stat_drop_cnt = 16'd0;
`endif

  // State register.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; enable low wins over a same-cycle byte.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable && buf_in_ready) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (!enable)
          w_state_nxt = (r_cnt != '0) ? S_COMMIT : S_IDLE;
        else if (w_write && (r_cnt == LP_CNT_LAST || s_last))
          w_state_nxt = S_COMMIT;
        else if (!w_write && r_cnt != '0 && r_timer == LP_TMR_LAST)
          w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        if (w_ack_hit) w_state_nxt = S_WAIT_ACK_LO;
      end
      S_WAIT_ACK_LO: begin
        if (!buf_in_commit_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Combinational outputs and handshake qualifiers, derived from state only.
  always_comb begin
    s_ready   = (r_state == S_FILL);
    w_accept  = s_ready && s_valid && enable;
    w_write   = w_accept && !w_drop;
    w_ack_hit = (r_state == S_COMMIT) && r_commit && buf_in_commit_ack;
  end

  // Byte count and idle timer; the timer only runs once a packet has content.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_timer <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt   <= '0;
      r_timer <= '0;
    end else if (r_state == S_FILL) begin
      if (w_write) begin
        r_cnt   <= r_cnt + 1'b1;
        r_timer <= '0;
      end else if (r_cnt != '0) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // Buffer write port: one-cycle strobe, address/data hold between writes.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= 8'd0;
    end else begin
      r_wren <= w_write;
      if (w_write) begin
        r_addr <= r_cnt[ADDR_W-1:0];
        r_data <= s_data;
      end
    end
  end

  // Commit request: raised one cycle into COMMIT, length held until next commit.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_commit     <= 1'b0;
      r_commit_len <= 11'd0;
    end else if (w_ack_hit) begin
      r_commit <= 1'b0;
    end else if (r_state == S_COMMIT && !r_commit) begin
      r_commit     <= 1'b1;
      r_commit_len <= 11'(r_cnt);
    end
  end

  // Committed packet counter, wraps.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n)       r_pkt_cnt <= 16'd0;
    else if (w_ack_hit) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end

  assign buf_in_addr       = r_addr;
  assign buf_in_data       = r_data;
  assign buf_in_wren       = r_wren;
  assign buf_in_commit     = r_commit;
  assign buf_in_commit_len = r_commit_len;
  assign stat_pkt_cnt      = r_pkt_cnt;

endmodule

// File: tb/tb_usb2_ep_in_packer.sv
`timescale 1ns/1ps
module tb_usb2_ep_in_packer;
  localparam int ADDR_W       = 11;
  localparam int MAX_PKT      = 512;
  localparam int FLUSH_CYCLES = 4096;

  logic              ext_clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] buf_in_addr;
  logic [7:0]        buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [10:0]       buf_in_commit_len;
  logic              buf_in_commit_ack;
  logic [15:0]       stat_pkt_cnt;
  logic [15:0]       stat_drop_cnt;

  int errors = 0;
  int checks = 0;

  usb2_ep_in_packer #(.ADDR_W(ADDR_W), .MAX_PKT(MAX_PKT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .ext_clk(ext_clk), .reset_n(reset_n), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 ext_clk = ~ext_clk;

  // Edge counter: at a negedge, cyc is the index of the preceding posedge.
  int cyc = 0;
  always @(posedge ext_clk) cyc <= cyc + 1;

  // Observation queues filled from the buffer port.
  int   wr_addr_q[$];
  int   wr_data_q[$];
  int   wr_cyc_q[$];
  int   cm_len_q[$];
  int   cm_cyc_q[$];
  int   sready_viol = 0;
  logic prev_commit = 1'b0;

  always @(negedge ext_clk) begin
    if (reset_n) begin
      if (buf_in_wren) begin
        wr_addr_q.push_back(int'(buf_in_addr));
        wr_data_q.push_back(int'(buf_in_data));
        wr_cyc_q.push_back(cyc);
      end
      if (buf_in_commit && !prev_commit) begin
        cm_len_q.push_back(int'(buf_in_commit_len));
        cm_cyc_q.push_back(cyc);
      end
      if ((buf_in_commit || buf_in_commit_ack) && s_ready) sready_viol <= sready_viol + 1;
    end
    prev_commit <= buf_in_commit;
  end

  // Host side: acknowledges each commit after a delay, releases after another.
  logic ack_rand = 1'b0;
  initial begin : ack_proc
    buf_in_commit_ack = 1'b0;
    forever begin
      @(negedge ext_clk);
      if (reset_n && buf_in_commit) begin
        int d1, d2, n;
        d1 = ack_rand ? int'($urandom_range(0, 4)) : 3;
        d2 = ack_rand ? int'($urandom_range(0, 4)) : 2;
        repeat (d1) @(negedge ext_clk);
        buf_in_commit_ack = 1'b1;
        n = 0;
        while (buf_in_commit && n < 100) begin @(negedge ext_clk); n++; end
        repeat (d2) @(negedge ext_clk);
        buf_in_commit_ack = 1'b0;
      end
    end
  end

  // Offer one byte (called at a negedge); returns the edge on which it was taken.
  task automatic send_byte(input logic [7:0] d, input logic l, output int acc_cyc);
    int n;
    logic r;
    n = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    do begin
      r = s_ready;
      @(negedge ext_clk);
      n++;
    end while (!r && n < 2000);
    acc_cyc = cyc;
    if (!r) begin
      errors++; checks++;
      $display("FAIL send_byte: s_ready stayed %0d for %0d cycles, required 1", r, n);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Wait for commit count to reach target, then for the handshake to finish.
  task automatic wait_commits(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (cm_len_q.size() < target && n < budget) begin @(negedge ext_clk); n++; end
    if (cm_len_q.size() < target) begin
      errors++; checks++;
      $display("FAIL %s commit_wait: commits=%0d, required %0d", nm, cm_len_q.size(), target);
    end
    n = 0;
    while ((buf_in_commit || buf_in_commit_ack) && n < 200) begin @(negedge ext_clk); n++; end
    repeat (2) @(negedge ext_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; buf_in_ready = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge ext_clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
    checks++; if ({buf_in_wren, buf_in_commit} !== 2'b00) begin errors++; $display("FAIL rst_strobes: wren=%b commit=%b, required 0", buf_in_wren, buf_in_commit); end
    checks++; if (buf_in_addr !== '0 || buf_in_data !== 8'h00 || buf_in_commit_len !== 11'd0) begin
      errors++; $display("FAIL rst_datapath: addr=%0d data=%0h len=%0d, required 0", buf_in_addr, buf_in_data, buf_in_commit_len); end
    checks++; if (stat_pkt_cnt !== 16'd0 || stat_drop_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_stats: pkt=%0d drop=%0d, required 0", stat_pkt_cnt, stat_drop_cnt); end
    reset_n = 1'b1;
    repeat (2) @(negedge ext_clk);
  endtask

`ifdef USB2_PACKER_TS_SYNC_EN
  task automatic test_ts_sync();
    int ac, base_w, base_c;
    logic [7:0] pre[3];
    pre[0] = 8'h12; pre[1] = 8'h34; pre[2] = 8'h56;
    enable = 1'b0; repeat (2) @(negedge ext_clk);
    enable = 1'b1; repeat (2) @(negedge ext_clk);
    base_w = wr_addr_q.size(); base_c = cm_len_q.size();
    for (int i = 0; i < 3; i++) send_byte(pre[i], 1'b0, ac);
    repeat (2) @(negedge ext_clk);
    checks++; if (stat_drop_cnt !== 16'd3) begin errors++; $display("FAIL ts_drop3: got %0d, required 3", stat_drop_cnt); end
    checks++; if (wr_addr_q.size() != base_w) begin errors++; $display("FAIL ts_nowrite: writes=%0d, required 0", wr_addr_q.size() - base_w); end
    for (int k = 0; k < 188; k++) send_byte((k == 0) ? 8'h47 : 8'($urandom_range(0, 255)), 1'b0, ac);
    send_byte(8'h99, 1'b0, ac);
    for (int k = 0; k < 188; k++) send_byte((k == 0) ? 8'h47 : 8'($urandom_range(0, 255)), k == 187, ac);
    wait_commits(base_c + 1, 500, "ts");
    checks++; if (wr_data_q[base_w] != 32'h47 || wr_addr_q[base_w] != 0) begin
      errors++; $display("FAIL ts_first_wr: data=%0h addr=%0d, required 47 at 0", wr_data_q[base_w], wr_addr_q[base_w]); end
    checks++; if (stat_drop_cnt !== 16'd4) begin errors++; $display("FAIL ts_drop4: got %0d, required 4", stat_drop_cnt); end
    checks++; if (cm_len_q[base_c] != 376) begin errors++; $display("FAIL ts_len: got %0d, required 376", cm_len_q[base_c]); end
    checks++; if (wr_addr_q.size() - base_w != 376) begin errors++; $display("FAIL ts_writes: got %0d, required 376", wr_addr_q.size() - base_w); end
    checks++; if (wr_data_q[base_w + 188] != 32'h47 || wr_addr_q[base_w + 188] != 188) begin
      errors++; $display("FAIL ts_second_sync: data=%0h addr=%0d, required 47 at 188", wr_data_q[base_w + 188], wr_addr_q[base_w + 188]); end
  endtask
`else
  task automatic test_full_packets();
    int ac, base_w, base_c, v0, bad;
    base_w = wr_addr_q.size(); base_c = cm_len_q.size(); v0 = sready_viol;
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b0, ac);
    wait_commits(base_c + 2, 3000, "full");
    for (int p = 0; p < 2; p++) begin
      checks++; if (cm_len_q[base_c + p] != MAX_PKT) begin
        errors++; $display("FAIL full_len%0d: got %0d, required %0d", p, cm_len_q[base_c + p], MAX_PKT); end
    end
    checks++; if (wr_addr_q.size() - base_w != 1024) begin
      errors++; $display("FAIL full_writes: got %0d, required 1024", wr_addr_q.size() - base_w); end
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (base_w + i >= wr_addr_q.size() || wr_addr_q[base_w + i] != i % MAX_PKT || wr_data_q[base_w + i] != i % 256) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL full_addr_data: %0d bad writes, required 0", bad); end
    checks++; if (stat_pkt_cnt !== 16'd2) begin errors++; $display("FAIL full_pkt_cnt: got %0d, required 2", stat_pkt_cnt); end
    checks++; if (sready_viol != v0) begin errors++; $display("FAIL full_sready_commit: %0d cycles high, required 0", sready_viol - v0); end
  endtask

  task automatic test_flush();
    int ac, base_c;
    base_c = cm_len_q.size();
    for (int i = 0; i < 100; i++) send_byte(8'(i + 7), 1'b0, ac);
    wait_commits(base_c + 1, FLUSH_CYCLES + 100, "flush");
    checks++; if (cm_cyc_q[base_c] - ac != FLUSH_CYCLES + 1) begin
      errors++; $display("FAIL flush_latency: got %0d, required %0d", cm_cyc_q[base_c] - ac, FLUSH_CYCLES + 1); end
    checks++; if (cm_len_q[base_c] != 100) begin errors++; $display("FAIL flush_len: got %0d, required 100", cm_len_q[base_c]); end
    repeat (300) @(negedge ext_clk);
    checks++; if (cm_len_q.size() != base_c + 1) begin
      errors++; $display("FAIL flush_idle_commit: commits=%0d, required %0d", cm_len_q.size() - base_c, 1); end
  endtask

  task automatic test_last();
    int ac, base_w, base_c;
    base_w = wr_addr_q.size(); base_c = cm_len_q.size();
    for (int i = 0; i < 37; i++) send_byte(8'(200 + i), i == 36, ac);
    wait_commits(base_c + 1, 300, "last");
    checks++; if (cm_len_q[base_c] != 37) begin errors++; $display("FAIL last_len: got %0d, required 37", cm_len_q[base_c]); end
    send_byte(8'h5A, 1'b1, ac);
    wait_commits(base_c + 2, 300, "last_next");
    checks++; if (wr_addr_q[base_w + 37] != 0 || wr_data_q[base_w + 37] != 32'h5A) begin
      errors++; $display("FAIL last_next_addr: addr=%0d data=%0h, required 0/5a", wr_addr_q[base_w + 37], wr_data_q[base_w + 37]); end
  endtask

  task automatic test_enable_low();
    int ac, base_w, base_c;
    base_w = wr_addr_q.size(); base_c = cm_len_q.size();
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1), 1'b0, ac);
    enable = 1'b0; s_valid = 1'b1; s_data = 8'hEE;
    @(negedge ext_clk);
    s_valid = 1'b0;
    wait_commits(base_c + 1, 300, "en_low");
    checks++; if (cm_len_q[base_c] != 10) begin errors++; $display("FAIL en_low_len: got %0d, required 10", cm_len_q[base_c]); end
    checks++; if (wr_addr_q.size() - base_w != 10) begin errors++; $display("FAIL en_low_writes: got %0d, required 10", wr_addr_q.size() - base_w); end
    enable = 1'b1;
    repeat (2) @(negedge ext_clk);
  endtask

  task automatic test_ready_gate();
    int ac, base_w, base_c, viol, c0;
    base_c = cm_len_q.size();
    buf_in_ready = 1'b0;
    send_byte(8'h11, 1'b1, ac);
    wait_commits(base_c + 1, 300, "rdy_close");
    s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
    viol = 0;
    repeat (50) begin
      @(negedge ext_clk);
      if (s_ready || buf_in_wren) viol++;
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL rdy_gate: %0d active cycles, required 0", viol); end
    base_w = wr_addr_q.size();
    buf_in_ready = 1'b1; c0 = cyc;
    send_byte(8'h77, 1'b1, ac);
    repeat (2) @(negedge ext_clk);
    checks++; if (wr_cyc_q[base_w] - c0 != 2 || wr_addr_q[base_w] != 0) begin
      errors++; $display("FAIL rdy_first_wr: latency=%0d addr=%0d, required 2/0", wr_cyc_q[base_w] - c0, wr_addr_q[base_w]); end
    wait_commits(base_c + 2, 300, "rdy_pkt");
  endtask

  task automatic test_reset_mid();
    int ac, base_w, base_c;
    for (int i = 0; i < 200; i++) send_byte(8'(i + 3), 1'b0, ac);
    base_c = cm_len_q.size();
    reset_n = 1'b0;
    #1;
    checks++; if ({s_ready, buf_in_wren, buf_in_commit} !== 3'b000) begin
      errors++; $display("FAIL rstmid_strobes: ready=%b wren=%b commit=%b, required 0", s_ready, buf_in_wren, buf_in_commit); end
    checks++; if (buf_in_addr !== '0 || buf_in_data !== 8'h00 || buf_in_commit_len !== 11'd0) begin
      errors++; $display("FAIL rstmid_datapath: addr=%0d data=%0h len=%0d, required 0", buf_in_addr, buf_in_data, buf_in_commit_len); end
    checks++; if (stat_pkt_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_pkt_cnt: got %0d, required 0", stat_pkt_cnt); end
    repeat (3) @(negedge ext_clk);
    reset_n = 1'b1;
    repeat (30) @(negedge ext_clk);
    checks++; if (cm_len_q.size() != base_c) begin errors++; $display("FAIL rstmid_no_commit: commits=%0d, required 0", cm_len_q.size() - base_c); end
    base_w = wr_addr_q.size();
    for (int i = 0; i < 3; i++) send_byte(8'(i + 40), i == 2, ac);
    wait_commits(base_c + 1, 300, "rstmid");
    checks++; if (wr_addr_q[base_w] != 0 || cm_len_q[base_c] != 3) begin
      errors++; $display("FAIL rstmid_restart: addr=%0d len=%0d, required 0/3", wr_addr_q[base_w], cm_len_q[base_c]); end
  endtask

  // Random stream against a chunking model: packets split at s_last or MAX_PKT.
  task automatic test_random();
    int ac, base_w, base_c, cur, bad_len, bad_wr;
    int exp_len[$];
    int exp_addr[$];
    int exp_data[$];
    logic [15:0] pkt0;
    logic [7:0]  d;
    logic        l;
    ack_rand = 1'b1;
    base_w = wr_addr_q.size(); base_c = cm_len_q.size(); pkt0 = stat_pkt_cnt;
    cur = 0;
    for (int i = 0; i < 1200; i++) begin
      d = 8'($urandom_range(0, 255));
      l = ($urandom_range(0, 39) == 0) || (i == 1199);
      exp_addr.push_back(cur); exp_data.push_back(int'(d));
      cur++;
      if (l || cur == MAX_PKT) begin exp_len.push_back(cur); cur = 0; end
      send_byte(d, l, ac);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge ext_clk);
    end
    wait_commits(base_c + exp_len.size(), 5000, "rand");
    bad_len = 0;
    foreach (exp_len[k]) if (cm_len_q[base_c + k] != exp_len[k]) bad_len++;
    checks++; if (bad_len != 0) begin errors++; $display("FAIL rand_lens: %0d wrong of %0d, required 0", bad_len, exp_len.size()); end
    bad_wr = 0;
    foreach (exp_addr[k])
      if (base_w + k >= wr_addr_q.size() || wr_addr_q[base_w + k] != exp_addr[k] || wr_data_q[base_w + k] != exp_data[k]) bad_wr++;
    checks++; if (bad_wr != 0) begin errors++; $display("FAIL rand_writes: %0d wrong of %0d, required 0", bad_wr, exp_addr.size()); end
    checks++; if (stat_pkt_cnt !== 16'(pkt0 + exp_len.size())) begin
      errors++; $display("FAIL rand_pkt_cnt: got %0d, required %0d", stat_pkt_cnt, 16'(pkt0 + exp_len.size())); end
    checks++; if (stat_drop_cnt !== 16'd0) begin errors++; $display("FAIL rand_drop_cnt: got %0d, required 0", stat_drop_cnt); end
    ack_rand = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef USB2_PACKER_TS_SYNC_EN
    test_ts_sync();
`else
    test_full_packets();
    test_flush();
    test_last();
    test_enable_low();
    test_ready_gate();
    test_reset_mid();
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/usb2_ep_in_packer.md
Name: usb2_ep_in_packer

Overview:
- Parametrised IN-endpoint packetiser in the ext_clk domain.
- Takes a byte stream from a producer (e.g. TS capture) and writes it into an endpoint buffer via the buf_in_addr/data/wren port.
- Closes packets on max length, explicit last, idle timeout or disable. Commits each packet with a 4-phase commit/commit_ack handshake.
- Successor to the hand-wired EP3 feeder: generic packet size, buffer width and flush policy.

Parameters:
ADDR_W, 11, endpoint buffer address width; MAX_PKT <= 2^ADDR_W
MAX_PKT, 512, bytes per full packet; 1..2047
FLUSH_CYCLES, 4096, idle ext_clk cycles before a partial packet is flushed; >=2

Ports:
ext_clk  in  1  block clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  packing enable
s_data  in  8  stream byte
s_valid  in  1  s_data valid
s_last  in  1  close packet after this byte
s_ready  out  1  byte accepted when s_valid&&s_ready
buf_in_addr  out  ADDR_W  buffer write address
buf_in_data  out  8  buffer write data
buf_in_wren  out  1  buffer write strobe
buf_in_ready  in  1  buffer free for filling
buf_in_commit  out  1  packet commit request (level)
buf_in_commit_len  out  11  committed byte count
buf_in_commit_ack  in  1  commit acknowledge (level)
stat_pkt_cnt  out  16  packets committed, wraps
stat_drop_cnt  out  16  bytes discarded, saturates at 0xFFFF

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0, including counters, addr, data and commit_len.
  - Any partial packet is discarded. No commit is issued after release.
- Internal counters:
  - Byte count cnt, width ADDR_W+1.
  - Idle timer, width clog2(FLUSH_CYCLES)+1.
- s_ready = (state==FILL). Combinational from state only, never from s_valid.
- IDLE:
  - Go to FILL when enable && buf_in_ready. Set cnt=0, timer=0.
- FILL, on accept (s_valid && s_ready):
  - Next cycle: buf_in_wren=1, buf_in_addr=cnt[ADDR_W-1:0], buf_in_data=s_data. Write latency is 1 cycle.
  - cnt increments. Timer clears.
  - If cnt+1==MAX_PKT or s_last, go to COMMIT. s_ready drops the following cycle, so no byte is accepted beyond the packet.
- FILL, no accept:
  - Timer increments when cnt>0.
  - When timer==FLUSH_CYCLES-1, go to COMMIT.
  - When cnt==0 the timer holds at 0. Zero-length packets are never committed.
- FILL, enable low:
  - cnt>0: go to COMMIT.
  - cnt==0: go to IDLE.
  - enable low takes priority over an accept in the same cycle; that byte is not accepted.
- COMMIT:
  - buf_in_commit=1 and buf_in_commit_len=cnt, both registered. The earliest commit rise is 2 cycles after the final accept, i.e. 1 cycle after the final wren.
  - commit_len stays stable until ack falls.
  - On buf_in_commit_ack=1: drop commit, stat_pkt_cnt++, go to WAIT_ACK_LO.
- WAIT_ACK_LO:
  - On ack==0, go to IDLE.
  - A new fill requires buf_in_ready again, so back-to-back packets need ready to re-assert.
- buf_in_wren is a single-cycle pulse per byte. buf_in_addr and buf_in_data hold their last value when wren=0.
- Simultaneous s_last with the MAX_PKT byte: one commit of length MAX_PKT.
- An ack arriving high before commit rises (stale) is ignored until the COMMIT state is reached. The handshake is strictly 4-phase.
- buf_in_ready falling during FILL is ignored. ready is sampled only in IDLE.

Optional Feature:
- Macro USB2_PACKER_TS_SYNC_EN.
- Defined:
  - A 0..187 position counter tracks TS packet alignment. It persists across USB packets and resets to 0 on reset or enable low.
  - If pos==0 and an accepted byte is not 0x47, the byte is consumed (s_ready stays high) but not written. cnt is unchanged, pos stays 0, and stat_drop_cnt increments.
  - Otherwise the byte is written and pos increments, wrapping 187->0.
  - Discarded bytes do not clear the idle timer.
- Undefined:
  - Every accepted byte is written.
  - stat_drop_cnt is tied to 0 and no position logic is built.

Test Plan:
1. Defaults. 1024 contiguous bytes 0x00..0xFF repeating; ready=1; ack returned 3 cycles after commit and released 2 cycles after commit falls -> two commits, each len 512, each with addr 0..511; stat_pkt_cnt=2; s_ready=0 throughout each COMMIT/WAIT_ACK_LO.
2. Defaults. 100 bytes then s_valid=0 -> commit rises with len 100 exactly FLUSH_CYCLES+1 cycles after the last accept; no further commit while idle.
3. s_last on byte 37 -> commit len 37. After ack low and ready=1, the next byte is written to addr 0.
4. buf_in_ready=0 with s_valid=1 -> s_ready=0 and no wren for 50 cycles. Raise ready -> first wren 2 cycles later at addr 0.
5. reset_n low at cnt=200 mid-FILL -> all outputs 0 in the same cycle (async). After release, no commit occurs and the next packet starts at addr 0.
6. USB2_PACKER_TS_SYNC_EN defined. Stream 0x12,0x34,0x56 followed by 188-byte packets starting 0x47 -> stat_drop_cnt=3; first wren data=0x47 at addr 0; a non-0x47 byte at a later pos==0 is dropped.
